// File: rtl/sig_check_pkg.sv
// -----------------------------------------------------------------------------
// sig_check_pkg
// Shared definitions for the y signature checker: FSM state encoding, default
// MISR polynomial and seed, and a ceiling-division helper used to size the fold.
// -----------------------------------------------------------------------------
package sig_check_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // CRC-32 polynomial; gives the MISR a long cycle without extra cost.
  localparam logic [31:0] DEFAULT_POLY = 32'h04C11DB7;
  localparam logic [31:0] DEFAULT_SEED = 32'h0000_0000;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/y_fold_xor.sv
// -----------------------------------------------------------------------------
// y_fold_xor
// Compacts a wide bus into SIG_WIDTH bits: y is zero-extended to a whole number
// of SIG_WIDTH chunks and all chunks are XORed together. Purely combinational.
// Ports:
//   y     in   Y_WIDTH    bus to fold
//   fold  out  SIG_WIDTH  XOR of all chunks
// -----------------------------------------------------------------------------
module y_fold_xor
  import sig_check_pkg::*;
#(
  parameter int Y_WIDTH   = 550,
  parameter int SIG_WIDTH = 32
) (
  input  logic [Y_WIDTH-1:0]   y,
  output logic [SIG_WIDTH-1:0] fold
);

  localparam int NUM_CHUNKS = ceil_div(Y_WIDTH, SIG_WIDTH);
  localparam int PAD_WIDTH  = NUM_CHUNKS * SIG_WIDTH;

  // Upper bits of the last chunk read as zero when Y_WIDTH is not a multiple.
  logic [PAD_WIDTH-1:0] y_padded;
  assign y_padded = PAD_WIDTH'(y);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    fold = '0;
    for (int i = 0; i < NUM_CHUNKS; i++) begin
      fold = fold ^ y_padded[i*SIG_WIDTH +: SIG_WIDTH];
    end
  end

endmodule

// File: rtl/y_signature_checker.sv
// -----------------------------------------------------------------------------
// y_signature_checker
// Consumes the DUT result bus y one sample per accepted cycle, compacts it into a
// MISR signature and, after NUM_VECTORS samples, compares it with a golden value.
// Ports:
//   clk           in   1          rising-edge clock
//   rst           in   1          asynchronous active-high reset
//   start         in   1          begin a run (honoured in IDLE and DONE only)
//   expected_sig  in   SIG_WIDTH  golden signature, latched on accepted start
//   y_valid       in   1          y carries a sample this cycle
//   y             in   Y_WIDTH    DUT output bus
//   busy          out  1          high in CAPTURE and COMPARE
//   done          out  1          high in DONE
//   pass          out  1          signature matched latched golden; valid with done
//   signature     out  SIG_WIDTH  current MISR value
//   sample_count  out  16         samples accepted this run
// -----------------------------------------------------------------------------
module y_signature_checker
  import sig_check_pkg::*;
#(
  parameter int                   Y_WIDTH     = 550,
  parameter int                   SIG_WIDTH   = 32,
  parameter int                   NUM_VECTORS = 21,
  parameter logic [SIG_WIDTH-1:0] POLY        = SIG_WIDTH'(DEFAULT_POLY),
  parameter logic [SIG_WIDTH-1:0] SEED        = SIG_WIDTH'(DEFAULT_SEED)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [SIG_WIDTH-1:0] expected_sig,
  input  logic                 y_valid,
  input  logic [Y_WIDTH-1:0]   y,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [SIG_WIDTH-1:0] signature,
  output logic [15:0]          sample_count
);

  localparam logic [15:0] LAST_COUNT = 16'(NUM_VECTORS - 1);

  state_t               state, state_next;
  logic [SIG_WIDTH-1:0] fold;
  logic [SIG_WIDTH-1:0] misr_next;
  logic [SIG_WIDTH-1:0] expected_q;
  logic                 start_ok;
  logic                 sample_ok;
  logic                 last_sample;

  y_fold_xor #(
    .Y_WIDTH   (Y_WIDTH),
    .SIG_WIDTH (SIG_WIDTH)
  ) u_fold (
    .y    (y),
    .fold (fold)
  );

  // start wins over a simultaneous y_valid because sample_ok needs CAPTURE.
  assign start_ok    = start && (state == IDLE || state == DONE);
  assign sample_ok   = y_valid && (state == CAPTURE);
  assign last_sample = sample_ok && (sample_count == LAST_COUNT);

  assign misr_next = {signature[SIG_WIDTH-2:0], 1'b0}
                   ^ (signature[SIG_WIDTH-1] ? POLY : '0)
                   ^ fold;

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DONE: if (start_ok)    state_next = CAPTURE;
      CAPTURE:    if (last_sample) state_next = COMPARE;
      COMPARE:                     state_next = DONE;
      default:                     state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      signature    <= SEED;
      sample_count <= '0;
      expected_q   <= '0;
      pass         <= 1'b0;
    end else if (start_ok) begin
      signature    <= SEED;
      sample_count <= '0;
      expected_q   <= expected_sig;
      pass         <= 1'b0;
    end else if (sample_ok) begin
      signature    <= misr_next;
      sample_count <= sample_count + 16'd1;
    end else if (state == COMPARE) begin
      pass <= (signature == expected_q);
    end
  end

  assign busy = (state == CAPTURE) || (state == COMPARE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_y_signature_checker.sv
module tb_y_signature_checker;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] Y_ONE_HI = 64'h0000_0001_0000_0000;

  // dut1: Y=64, SIG=32, N=2, default seed/poly
  logic        start1 = 0, valid1 = 0;
  logic [31:0] exp1 = '0;
  logic [63:0] y1 = '0;
  logic        busy1, done1, pass1;
  logic [31:0] sig1;
  logic [15:0] cnt1;

  y_signature_checker #(.Y_WIDTH(64), .SIG_WIDTH(32), .NUM_VECTORS(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .expected_sig(exp1), .y_valid(valid1),
    .y(y1), .busy(busy1), .done(done1), .pass(pass1), .signature(sig1), .sample_count(cnt1));

  // dut2: N=1, SEED=8000_0000
  logic        start2 = 0, valid2 = 0;
  logic [31:0] exp2 = '0;
  logic [63:0] y2 = '0;
  logic        busy2, done2, pass2;
  logic [31:0] sig2;
  logic [15:0] cnt2;

  y_signature_checker #(.Y_WIDTH(64), .SIG_WIDTH(32), .NUM_VECTORS(1),
                        .SEED(32'h8000_0000)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .expected_sig(exp2), .y_valid(valid2),
    .y(y2), .busy(busy2), .done(done2), .pass(pass2), .signature(sig2), .sample_count(cnt2));

  // dut3: default parameters (550-bit y, 21 vectors)
  logic         start3 = 0, valid3 = 0;
  logic [31:0]  exp3 = '0;
  logic [549:0] y3 = '0;
  logic         busy3, done3, pass3;
  logic [31:0]  sig3;
  logic [15:0]  cnt3;

  y_signature_checker dut3 (
    .clk(clk), .rst(rst), .start(start3), .expected_sig(exp3), .y_valid(valid3),
    .y(y3), .busy(busy3), .done(done3), .pass(pass3), .signature(sig3), .sample_count(cnt3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic b, input logic d, input logic p,
                      input logic [31:0] s, input logic [15:0] c);
    checks++;
    if ({busy1, done1, pass1, sig1, cnt1} !== {b, d, p, s, c}) begin
      errors++;
      $display("FAIL %s: got busy=%b done=%b pass=%b sig=%h cnt=%0d, want busy=%b done=%b pass=%b sig=%h cnt=%0d",
               name, busy1, done1, pass1, sig1, cnt1, b, d, p, s, c);
    end
  endtask

  // Scenario 1 run on dut1 from IDLE/DONE: samples 1 then 3, pass with expected 3.
  task automatic run_basic(input string tag);
    start1 = 1; exp1 = 32'd3; tick();
    start1 = 0;
    chk1({tag, "_started"}, 1, 0, 0, 32'd0, 16'd0);
    y1 = Y_ONE_HI; valid1 = 1; tick();
    chk1({tag, "_sample1"}, 1, 0, 0, 32'd1, 16'd1);
    tick();
    valid1 = 0;
    chk1({tag, "_sample2"}, 1, 0, 0, 32'd3, 16'd2);
    tick();
    chk1({tag, "_done"}, 0, 1, 1, 32'd3, 16'd2);
  endtask

  task automatic test_reset();
    rst = 1; #12; rst = 0; #1;
    chk1("reset1", 0, 0, 0, 32'd0, 16'd0);
    checks++;
    if ({busy2, done2, pass2, sig2, cnt2} !== {3'b000, 32'h8000_0000, 16'd0}) begin
      errors++;
      $display("FAIL reset2: got sig=%h cnt=%0d flags=%b%b%b, want sig=80000000 cnt=0 flags=000",
               sig2, cnt2, busy2, done2, pass2);
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_basic("basic");
    // DONE ignores y_valid and holds results.
    valid1 = 1; y1 = Y_ONE_HI; tick(); tick(); valid1 = 0;
    chk1("done_hold", 0, 1, 1, 32'd3, 16'd2);
  endtask

  task automatic test_gaps();
    start1 = 1; exp1 = 32'd3; tick(); start1 = 0;
    y1 = Y_ONE_HI;
    valid1 = 1; tick();
    valid1 = 0; start1 = 1; tick();
    chk1("gap_start_ignored", 1, 0, 0, 32'd1, 16'd1);
    start1 = 0; tick();
    valid1 = 1; tick(); valid1 = 0;
    chk1("gap_sample2", 1, 0, 0, 32'd3, 16'd2);
    tick();
    chk1("gap_done", 0, 1, 1, 32'd3, 16'd2);
  endtask

  task automatic test_async_reset();
    start1 = 1; exp1 = 32'd3; tick(); start1 = 0;
    y1 = Y_ONE_HI; valid1 = 1; tick(); valid1 = 0;
    chk1("pre_rst", 1, 0, 0, 32'd1, 16'd1);
    #2 rst = 1; #1;
    chk1("async_rst", 0, 0, 0, 32'd0, 16'd0);
    #1 rst = 0;
    @(negedge clk);
    run_basic("after_rst");
  endtask

  task automatic test_restart_collision();
    // dut1 is in DONE with signature 3.
    start1 = 1; valid1 = 1; y1 = Y_ONE_HI; exp1 = 32'd3; tick();
    start1 = 0; valid1 = 0;
    chk1("restart_collide", 1, 0, 0, 32'd0, 16'd0);
    valid1 = 1; tick(); tick(); valid1 = 0;
    chk1("restart_run", 1, 0, 0, 32'd3, 16'd2);
    tick();
    chk1("restart_done", 0, 1, 1, 32'd3, 16'd2);
  endtask

  task automatic test_seed_poly();
    start2 = 1; exp2 = 32'h04C1_1DB6; tick(); start2 = 0;
    y2 = '0; valid2 = 1; tick(); valid2 = 0;
    checks++;
    if ({sig2, cnt2, busy2, done2} !== {32'h04C1_1DB7, 16'd1, 2'b10}) begin
      errors++;
      $display("FAIL seed_poly_sig: got sig=%h cnt=%0d busy=%b done=%b, want 04c11db7 1 1 0",
               sig2, cnt2, busy2, done2);
    end
    tick();
    checks++;
    if ({done2, pass2} !== 2'b10) begin
      errors++;
      $display("FAIL seed_poly_fail: got done=%b pass=%b, want done=1 pass=0", done2, pass2);
    end
  endtask

  // Each sample sets only bit 549 (bit 5 of the padded top chunk), so fold=0x20
  // and the signature after n samples is (2^n-1)<<5: 21 samples -> 03FF_FFE0.
  task automatic run_wide(input bit flip, output logic p, output logic d,
                          output logic [15:0] c);
    start3 = 1; exp3 = 32'h03FF_FFE0; tick(); start3 = 0;
    for (int i = 0; i < 21; i++) begin
      y3 = '0; y3[549] = 1'b1;
      if (flip && i == 10) y3[0] = 1'b1;
      valid3 = 1; tick();
      if (i == 0 && !flip) begin
        checks++;
        if (sig3 !== 32'h0000_0020) begin
          errors++;
          $display("FAIL wide_fold_top_chunk: got sig=%h want 00000020", sig3);
        end
      end
    end
    valid3 = 0;
    tick();
    // Extra valids in DONE must not move the count past 21.
    valid3 = 1; tick(); valid3 = 0;
    p = pass3; d = done3; c = cnt3;
  endtask

  task automatic test_wide();
    logic p, d;
    logic [15:0] c;
    run_wide(0, p, d, c);
    checks++;
    if ({d, p, c, sig3} !== {2'b11, 16'd21, 32'h03FF_FFE0}) begin
      errors++;
      $display("FAIL wide_pass: got done=%b pass=%b cnt=%0d sig=%h, want 1 1 21 03ffffe0",
               d, p, c, sig3);
    end
    run_wide(1, p, d, c);
    checks++;
    if ({d, p, c} !== {2'b10, 16'd21}) begin
      errors++;
      $display("FAIL wide_flip: got done=%b pass=%b cnt=%0d, want done=1 pass=0 cnt=21", d, p, c);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_async_reset();
    test_restart_collision();
    test_seed_poly();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
